// File: rtl/conv_pool_sequencer_pkg.sv
// Shared types and helpers for the conv/pool sequencer: FSM states, quad
// offsets inside a 2x2 pool tile and the pooled-map address calculation.
package conv_pool_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  // Bit q of each mask is the x/y offset of quad position q:
  // q0=(0,0), q1=(1,0), q2=(0,1), q3=(1,1).
  localparam logic [3:0] QUAD_DX = 4'b1010;
  localparam logic [3:0] QUAD_DY = 4'b1100;

  function automatic logic [31:0] pool_address(input logic [6:0] px,
                                               input logic [6:0] py,
                                               input int unsigned half_w);
    return 32'(py) * half_w + 32'(px);
  endfunction

endpackage

// File: rtl/pool_quad_max.sv
// Response side of the sequencer: sums CHANNEL conv results per position,
// keeps the running max over the four positions of a tile and emits it registered.
module pool_quad_max
  import conv_pool_sequencer_pkg::*;
#(
  parameter int WIDTH   = 28,
  parameter int HEIGHT  = 28,
  parameter int CHANNEL = 1,
  parameter int ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              resp_valid_i,
  input  logic [7:0]        resp_data_i,
  output logic              pool_valid_o,
  output logic [7:0]        pool_data_o,
  output logic [ADDR_W-1:0] pool_addr_o,
  output logic              pool_last_o
);

  localparam logic [6:0]  PX_LAST = 7'(WIDTH / 2 - 1);
  localparam logic [6:0]  PY_LAST = 7'(HEIGHT / 2 - 1);
  localparam logic [7:0]  CH_LAST = 8'(CHANNEL - 1);
  localparam int unsigned HALF_W  = WIDTH / 2;

  logic [7:0]        ch_q, ch_d;
  logic [1:0]        quad_q, quad_d;
  logic [6:0]        px_q, px_d, py_q, py_d;
  logic [7:0]        acc_q, acc_d, max_q, max_d;
  logic              pool_valid_q, pool_valid_d, pool_last_q, pool_last_d;
  logic [7:0]        pool_data_q, pool_data_d;
  logic [ADDR_W-1:0] pool_addr_q, pool_addr_d;
  logic [7:0]        pos_sum, tile_max;

  always_comb begin
    ch_d         = ch_q;
    quad_d       = quad_q;
    px_d         = px_q;
    py_d         = py_q;
    acc_d        = acc_q;
    max_d        = max_q;
    pool_valid_d = 1'b0;
    pool_data_d  = pool_data_q;
    pool_addr_d  = pool_addr_q;
    pool_last_d  = pool_last_q;
    pos_sum      = (ch_q == 8'd0) ? resp_data_i : acc_q + resp_data_i;
    tile_max     = (quad_q == 2'd0 || pos_sum > max_q) ? pos_sum : max_q;

    if (clear_i) begin
      ch_d   = '0;
      quad_d = '0;
      px_d   = '0;
      py_d   = '0;
      acc_d  = '0;
      max_d  = '0;
    end else if (resp_valid_i) begin
      acc_d = pos_sum;
      if (ch_q == CH_LAST) begin
        ch_d   = '0;
        quad_d = quad_q + 2'd1;
        max_d  = tile_max;
        // Fourth position closes the tile: publish max and advance the tile walk.
        if (quad_q == 2'd3) begin
          pool_valid_d = 1'b1;
          pool_data_d  = tile_max;
          pool_addr_d  = ADDR_W'(pool_address(px_q, py_q, HALF_W));
          pool_last_d  = (px_q == PX_LAST) && (py_q == PY_LAST);
          if (px_q == PX_LAST) begin
            px_d = '0;
            py_d = (py_q == PY_LAST) ? 7'd0 : py_q + 7'd1;
          end else begin
            px_d = px_q + 7'd1;
          end
        end
      end else begin
        ch_d = ch_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_q         <= '0;
      quad_q       <= '0;
      px_q         <= '0;
      py_q         <= '0;
      acc_q        <= '0;
      max_q        <= '0;
      pool_valid_q <= 1'b0;
      pool_data_q  <= '0;
      pool_addr_q  <= '0;
      pool_last_q  <= 1'b0;
    end else begin
      ch_q         <= ch_d;
      quad_q       <= quad_d;
      px_q         <= px_d;
      py_q         <= py_d;
      acc_q        <= acc_d;
      max_q        <= max_d;
      pool_valid_q <= pool_valid_d;
      pool_data_q  <= pool_data_d;
      pool_addr_q  <= pool_addr_d;
      pool_last_q  <= pool_last_d;
    end
  end

  assign pool_valid_o = pool_valid_q;
  assign pool_data_o  = pool_data_q;
  assign pool_addr_o  = pool_addr_q;
  assign pool_last_o  = pool_last_q;

endmodule

// File: rtl/conv_pool_sequencer.sv
// Layer controller: walks output positions in pool-tile order issuing per-channel
// window requests, tracks outstanding work and hands responses to pool_quad_max.
module conv_pool_sequencer
  import conv_pool_sequencer_pkg::*;
#(
  parameter int WIDTH   = 28,
  parameter int HEIGHT  = 28,
  parameter int CHANNEL = 1,
  parameter int MAX_OUT = 4,
  parameter int ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [7:0]        win_x,
  output logic [7:0]        win_y,
  output logic [7:0]        win_c,
  input  logic              conv_valid,
  input  logic [7:0]        conv_data,
  output logic              pool_valid,
  output logic [7:0]        pool_data,
  output logic [ADDR_W-1:0] pool_addr
);

  localparam logic [6:0] PX_LAST   = 7'(WIDTH / 2 - 1);
  localparam logic [6:0] PY_LAST   = 7'(HEIGHT / 2 - 1);
  localparam logic [7:0] CH_LAST   = 8'(CHANNEL - 1);
  localparam logic [3:0] MAX_OUT_C = 4'(MAX_OUT);

  state_e     state_q, state_d;
  logic [7:0] ch_q, ch_d;
  logic [1:0] quad_q, quad_d;
  logic [6:0] px_q, px_d, py_q, py_d;
  logic [3:0] out_q, out_d;
  logic       err_q, err_d;
  logic       start_acc, handshake, resp_ok, last_req, pool_last;

  assign start_acc = (state_q == IDLE) && start;
  assign win_valid = (state_q == RUN) && (out_q < MAX_OUT_C);
  assign handshake = win_valid && win_ready;
  assign resp_ok   = conv_valid && (out_q != 4'd0);
  assign last_req  = (ch_q == CH_LAST) && (quad_q == 2'd3) &&
                     (px_q == PX_LAST) && (py_q == PY_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (handshake && last_req) state_d = DRAIN;
      DRAIN:   if (pool_valid && pool_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Issue walk: channel fastest, then quad position, then tile column, then row.
  always_comb begin
    ch_d   = ch_q;
    quad_d = quad_q;
    px_d   = px_q;
    py_d   = py_q;
    if (start_acc) begin
      ch_d   = '0;
      quad_d = '0;
      px_d   = '0;
      py_d   = '0;
    end else if (handshake) begin
      if (ch_q == CH_LAST) begin
        ch_d   = '0;
        quad_d = quad_q + 2'd1;
        if (quad_q == 2'd3) begin
          if (px_q == PX_LAST) begin
            px_d = '0;
            py_d = (py_q == PY_LAST) ? 7'd0 : py_q + 7'd1;
          end else begin
            px_d = px_q + 7'd1;
          end
        end
      end else begin
        ch_d = ch_q + 8'd1;
      end
    end
  end

  always_comb begin
    out_d = out_q;
    err_d = err_q;
    if (start_acc) begin
      out_d = '0;
      err_d = 1'b0;
    end else begin
      case ({handshake, resp_ok})
        2'b10:   out_d = out_q + 4'd1;
        2'b01:   out_d = out_q - 4'd1;
        default: out_d = out_q;
      endcase
      if (conv_valid && !resp_ok) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ch_q    <= '0;
      quad_q  <= '0;
      px_q    <= '0;
      py_q    <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      quad_q  <= quad_d;
      px_q    <= px_d;
      py_q    <= py_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  assign busy  = (state_q == RUN) || (state_q == DRAIN);
  assign done  = (state_q == DONE);
  assign err   = err_q;
  assign win_x = {px_q, QUAD_DX[quad_q]};
  assign win_y = {py_q, QUAD_DY[quad_q]};
  assign win_c = ch_q;

  pool_quad_max #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .CHANNEL(CHANNEL),
    .ADDR_W (ADDR_W)
  ) u_pool (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (start_acc),
    .resp_valid_i(resp_ok),
    .resp_data_i (conv_data),
    .pool_valid_o(pool_valid),
    .pool_data_o (pool_data),
    .pool_addr_o (pool_addr),
    .pool_last_o (pool_last)
  );

endmodule

// File: tb/tb_conv_pool_sequencer.sv
// Scoreboard bench: a conv-engine model answers requests, expected pooled results
// are queued as requests are issued and popped when the sequencer emits them.
module tb_conv_pool_sequencer;

  localparam int W = 4;
  localparam int H = 4;
  localparam int C = 2;
  localparam int MO = 4;
  localparam int AW = 16;
  localparam int LAT = 2;
  localparam int TOTAL_REQ = W * H * C;
  localparam int TOTAL_POOL = W * H / 4;

  logic clk = 1'b0;
  logic rst, start, winReady, convValid;
  logic [7:0] convData;
  logic busy, done, err, winValid, poolValid;
  logic [7:0] winX, winY, winC, poolData;
  logic [AW-1:0] poolAddr;

  conv_pool_sequencer #(
    .WIDTH(W), .HEIGHT(H), .CHANNEL(C), .MAX_OUT(MO), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .win_valid(winValid), .win_ready(winReady), .win_x(winX), .win_y(winY),
    .win_c(winC), .conv_valid(convValid), .conv_data(convData),
    .pool_valid(poolValid), .pool_data(poolData), .pool_addr(poolAddr)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] data; int due; } engItem_t;
  typedef struct { logic [7:0] data; logic [AW-1:0] addr; } poolItem_t;

  engItem_t  engQ[$];
  poolItem_t sbQ[$];

  int tests = 0;
  int fails = 0;
  int cycle = 0;
  int mode, reqCount, poolCount, benchOut;
  bit hold, doneDue, donePassed, prevStall;
  logic [7:0] prevX, prevY, prevC, mSum, mMax;
  logic [7:0] mode0Exp [4] = '{8'd5, 8'd7, 8'd13, 8'd15};

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  function automatic logic [7:0] respValue(input int x, input int y, input int c);
    case (mode)
      0:       return (c == 0) ? 8'(x + 4 * y) : 8'd0;
      1:       return (c == 0) ? 8'd200 : 8'd100;
      default: return 8'(x * 37 + y * 11 + c * 101 + 3);
    endcase
  endfunction

  // One clock cycle: check what the DUT shows now, drive inputs for the next edge.
  task automatic applyStimulus();
    bit nextDue;
    int ch, pos, quad, tile, px, py, ex, ey;
    logic [7:0] v;
    poolItem_t e;
    nextDue = 1'b0;

    checkOutput("done_timing", done, doneDue);
    if (doneDue) begin
      checkOutput("busy_drop", busy, 0);
      donePassed = 1'b1;
    end
    if (poolValid) begin
      if (sbQ.size() == 0) checkOutput("pool_extra", 1, 0);
      else begin
        e = sbQ.pop_front();
        checkOutput("pool_data", poolData, e.data);
        checkOutput("pool_addr", poolAddr, e.addr);
        if (mode == 0 && poolCount < 4) checkOutput("pool_const", poolData, mode0Exp[poolCount]);
      end
      poolCount++;
      if (poolCount == TOTAL_POOL) nextDue = 1'b1;
    end
    if (prevStall) begin
      checkOutput("stall_valid", winValid, 1);
      checkOutput("stall_x", winX, prevX);
      checkOutput("stall_y", winY, prevY);
      checkOutput("stall_c", winC, prevC);
    end
    checkOutput("win_valid", winValid, (reqCount < TOTAL_REQ) && (benchOut < MO));

    winReady = (mode == 2) ? ($urandom_range(99, 0) >= 40) : 1'b1;
    convValid = 1'b0;
    if (!hold && engQ.size() > 0 && engQ[0].due <= cycle) begin
      convValid = 1'b1;
      convData = engQ[0].data;
      void'(engQ.pop_front());
      benchOut--;
    end
    if (winValid && winReady) begin
      ch = reqCount % C;  pos = reqCount / C;  quad = pos % 4;  tile = pos / 4;
      px = tile % (W / 2);  py = tile / (W / 2);
      ex = 2 * px + (quad % 2);  ey = 2 * py + quad / 2;
      checkOutput("req_x", winX, ex);
      checkOutput("req_y", winY, ey);
      checkOutput("req_c", winC, ch);
      v = respValue(ex, ey, ch);
      engQ.push_back('{v, cycle + LAT});
      mSum = (ch == 0) ? v : mSum + v;
      if (ch == C - 1) begin
        mMax = (quad == 0 || mSum > mMax) ? mSum : mMax;
        if (quad == 3) sbQ.push_back('{mMax, AW'(py * (W / 2) + px)});
      end
      reqCount++;
      benchOut++;
    end
    prevStall = winValid && !winReady;
    prevX = winX;  prevY = winY;  prevC = winC;
    doneDue = nextDue;
    @(negedge clk);
    cycle++;
  endtask

  task automatic runPass(input int m, input int holdCycles, input bit pokeStart,
                         input int abortAt);
    mode = m;  reqCount = 0;  poolCount = 0;  benchOut = 0;
    engQ.delete();  sbQ.delete();
    doneDue = 0;  donePassed = 0;  prevStall = 0;
    winReady = 0;  convValid = 0;
    checkOutput("idle_busy", busy, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_start", busy, 1);
    checkOutput("err_cleared", err, 0);
    hold = (holdCycles > 0);
    for (int s = 0; s < 3000 && !donePassed; s++) begin
      if (abortAt > 0 && s == abortAt) break;
      if (holdCycles > 0 && s == holdCycles) begin
        checkOutput("held_handshakes", reqCount, MO);
        checkOutput("held_win_valid", winValid, 0);
        hold = 1'b0;
      end
      start = pokeStart && (s == 6);
      applyStimulus();
    end
    start = 1'b0;
    if (abortAt == 0) begin
      if (!donePassed) checkOutput("pass_timeout", 0, 1);
      checkOutput("req_count", reqCount, TOTAL_REQ);
      checkOutput("sb_empty", sbQ.size(), 0);
      checkOutput("err_end", err, 0);
      checkOutput("done_pulse", done, 0);
      checkOutput("idle_win_valid", winValid, 0);
    end
  endtask

  initial begin
    rst = 1'b1;  start = 0;  winReady = 0;  convValid = 0;  convData = 0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_win_valid", winValid, 0);
    checkOutput("rst_pool", {poolValid, poolData, poolAddr}, 0);
    checkOutput("rst_xyc", {winX, winY, winC}, 0);
    rst = 1'b0;
    @(negedge clk);

    runPass(0, 0, 1'b1, 0);
    runPass(1, 0, 1'b0, 0);
    runPass(2, 0, 1'b0, 0);
    runPass(3, 10, 1'b0, 0);

    runPass(0, 0, 1'b0, 16);
    #3 rst = 1'b1;
    #1;
    checkOutput("async_busy", busy, 0);
    checkOutput("async_done_err", {done, err}, 0);
    checkOutput("async_win", {winValid, winX, winY, winC}, 0);
    checkOutput("async_pool", {poolValid, poolData, poolAddr}, 0);
    @(negedge clk);
    rst = 1'b0;
    winReady = 1'b0;
    convValid = 1'b1;
    convData = 8'd9;
    @(negedge clk);
    convValid = 1'b0;
    checkOutput("err_spurious", err, 1);
    @(negedge clk);
    checkOutput("err_sticky", err, 1);
    checkOutput("idle_after_rst", busy, 0);

    runPass(0, 0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
